bcd_scan_display: RTL and testbench

Display-side consumer of the BCD countdown counter. Takes the counter's packed two-digit BCD value and its carry/timeout flag, multiplexes four common-anode seven-segment digits (countdown on digits 1..0, running BCD timeout tally on digits 3..2), and blanks-and-flashes the display a fixed number of times on every timeout. Sits between the countdown counter and the board's segment/anode pins.

---
 rtl/bcd_scan_display_if.sv | 28 ++
 rtl/bcd_scan_display.sv | 202 ++++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Signal bundle between the countdown counter / board pins and the scanning display driver.
// The master side supplies the count, timeout flag and enable; the slave side returns pins and tally.
interface bcd_scan_display_if;
   logic [7:0] bcd_in;
   logic       carry_in;
   logic       enable;
   logic [7:0] seg;
   logic [3:0] an;
   logic [7:0] tally;

   modport master (
      output bcd_in,
      output carry_in,
      output enable,
      input  seg,
      input  an,
      input  tally
   );

   modport slave (
      input  bcd_in,
      input  carry_in,
      input  enable,
      output seg,
      output an,
      output tally
   );
endinterface

// File: rtl/bcd_scan_display.sv
// Four-digit common-anode scanner: countdown on digits 1..0, BCD timeout tally on digits 3..2,
// with a blank-and-flash sequence started by every rising edge of the counter's carry flag.
module bcd_scan_display #(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_HALF  = 64,
   parameter int BLINK_COUNT = 3,
   parameter bit LZB         = 1'b1
) (
   input logic               clk,
   input logic               reset,
   bcd_scan_display_if.slave bus
);
   localparam int               DIV_W       = $clog2(SCAN_DIV);
   localparam int               HC_W        = $clog2(BLINK_HALF + 1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
   localparam logic [HC_W-1:0]  HC_LAST     = HC_W'(BLINK_HALF - 1);
   localparam logic [3:0]       REMAIN_INIT = 4'(BLINK_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OFF  = 2'd1,
      ON   = 2'd2
   } flash_state_t;

   function automatic logic [7:0] seg_decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hBF;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [3:0] ones;
      logic [3:0] tens;
      ones = v[3:0];
      tens = v[7:4];
      if (ones >= 4'd9) begin
         ones = 4'd0;
         if (tens >= 4'd9) begin
            tens = 4'd0;
         end else begin
            tens = tens + 4'd1;
         end
      end else begin
         ones = ones + 4'd1;
      end
      return {tens, ones};
   endfunction

   logic [DIV_W-1:0] div_r;
   logic [1:0]       idx_r;
   logic             carry_d_r;
   logic [7:0]       tally_r;
   flash_state_t     state_r, state_nx_s;
   logic [3:0]       remain_r, remain_nx_s;
   logic [HC_W-1:0]  hc_r, hc_nx_s;
   logic [7:0]       seg_r, seg_next_s;
   logic [3:0]       an_r, an_next_s;
   logic             tick_s;
   logic             edge_s;
   logic [3:0]       digit_s;
   logic             blank_s;
   logic             dp_s;

   assign tick_s    = (div_r == DIV_LAST);
   assign edge_s    = bus.carry_in & ~carry_d_r;
   assign bus.seg   = seg_r;
   assign bus.an    = an_r;
   assign bus.tally = tally_r;

   // Slot divider and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_r <= '0;
         idx_r <= 2'd0;
      end else if (tick_s) begin
         div_r <= '0;
         idx_r <= idx_r + 2'd1;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Carry edge detect and timeout tally; carry_d resets high so a held carry is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         carry_d_r <= 1'b1;
         tally_r   <= 8'h00;
      end else begin
         carry_d_r <= bus.carry_in;
         if (edge_s) begin
            tally_r <= bcd_inc(tally_r);
         end
      end
   end

   // Digit source selection and segment pattern for the current slot.
   always_comb begin
      digit_s   = 4'd0;
      blank_s   = 1'b0;
      dp_s      = 1'b0;
      an_next_s = ~(4'b0001 << idx_r);
      case (idx_r)
         2'd0: digit_s = bus.bcd_in[3:0];
         2'd1: begin
            digit_s = bus.bcd_in[7:4];
            blank_s = LZB && (bus.bcd_in[7:4] == 4'd0);
         end
         2'd2: begin
            digit_s = tally_r[3:0];
            dp_s    = 1'b1;
         end
         2'd3: digit_s = tally_r[7:4];
         default: digit_s = 4'd0;
      endcase
      if (blank_s) begin
         seg_next_s = 8'hFF;
      end else if (dp_s) begin
         seg_next_s = seg_decode(digit_s) & 8'h7F;
      end else begin
         seg_next_s = seg_decode(digit_s);
      end
   end

   // Flash sequencer next state; a carry edge restarts the sequence ahead of any tick.
   always_comb begin
      state_nx_s  = state_r;
      remain_nx_s = remain_r;
      hc_nx_s     = hc_r;
      if (edge_s) begin
         state_nx_s  = OFF;
         remain_nx_s = REMAIN_INIT;
         hc_nx_s     = '0;
      end else if (tick_s) begin
         case (state_r)
            OFF: begin
               if (hc_r == HC_LAST) begin
                  state_nx_s = ON;
                  hc_nx_s    = '0;
               end else begin
                  hc_nx_s = hc_r + HC_W'(1);
               end
            end
            ON: begin
               if (hc_r == HC_LAST) begin
                  hc_nx_s = '0;
                  if (remain_r == 4'd1) begin
                     state_nx_s = IDLE;
                  end else begin
                     remain_nx_s = remain_r - 4'd1;
                     state_nx_s  = OFF;
                  end
               end else begin
                  hc_nx_s = hc_r + HC_W'(1);
               end
            end
            IDLE:    hc_nx_s    = '0;
            default: state_nx_s = IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Flash sequencer state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IDLE;
         remain_r <= 4'd0;
         hc_r     <= '0;
      end else begin
         state_r  <= state_nx_s;
         remain_r <= remain_nx_s;
         hc_r     <= hc_nx_s;
      end
   end

   // Pin registers: blanking applies every clock, digit loads only on ticks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_r <= 8'hFF;
         an_r  <= 4'hF;
      end else if ((state_r == OFF) || !bus.enable) begin
         seg_r <= 8'hFF;
         an_r  <= 4'hF;
      end else if (tick_s) begin
         seg_r <= seg_next_s;
         an_r  <= an_next_s;
      end
   end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: scan order, decode, leading-zero blanking,
// carry edge/tally, flash sequencing, enable blanking and reset mid-flash.
module tb_bcd_scan_display;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   bcd_scan_display_if bus1();
   bcd_scan_display_if bus0();

   assign bus0.bcd_in   = bus1.bcd_in;
   assign bus0.carry_in = bus1.carry_in;
   assign bus0.enable   = bus1.enable;

   bcd_scan_display #(.SCAN_DIV(4), .BLINK_HALF(2), .BLINK_COUNT(2), .LZB(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   bcd_scan_display #(.SCAN_DIV(4), .BLINK_HALF(2), .BLINK_COUNT(2), .LZB(1'b0)) dut_nlzb (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
      check({tag, "_an"}, 32'(bus1.an), 32'(an_exp));
      check({tag, "_seg"}, 32'(bus1.seg), 32'(seg_exp));
   endtask

   initial begin
      logic [7:0] exp_tally;
      reset         = 1'b0;
      bus1.bcd_in   = 8'h24;
      bus1.carry_in = 1'b0;
      bus1.enable   = 1'b1;
      cycles(2);
      check_disp("reset", 4'hF, 8'hFF);
      check("reset_tally", 32'(bus1.tally), 32'h00);
      reset = 1'b1;

      // Frame with 24: ones, tens, tally ones with dp, tally tens
      cycles(4);
      check_disp("scan0", 4'b1110, 8'h99);
      cycles(4);
      check_disp("scan1", 4'b1101, 8'hA4);
      cycles(4);
      check_disp("scan2", 4'b1011, 8'h40);
      cycles(4);
      check_disp("scan3", 4'b0111, 8'hC0);

      // Leading-zero blanking and dash for non-BCD nibble
      bus1.bcd_in = 8'h07;
      cycles(4);
      check_disp("d07_0", 4'b1110, 8'hF8);
      cycles(4);
      check_disp("lzb1", 4'b1101, 8'hFF);
      check("nlzb_seg", 32'(bus0.seg), 32'hC0);
      cycles(8);
      bus1.bcd_in = 8'h3A;
      cycles(4);
      check_disp("dash", 4'b1110, 8'hBF);

      // Carry held high through reset release is not counted
      reset         = 1'b0;
      bus1.bcd_in   = 8'h24;
      bus1.carry_in = 1'b1;
      cycles(2);
      check_disp("rst2", 4'hF, 8'hFF);
      reset = 1'b1;
      cycles(4);
      check_disp("held0", 4'b1110, 8'h99);
      check("held_tally", 32'(bus1.tally), 32'h00);
      cycles(4);
      check_disp("held1", 4'b1101, 8'hA4);

      // Fresh edge: tally one clock later, blanking one clock after that
      bus1.carry_in = 1'b0;
      cycles(1);
      bus1.carry_in = 1'b1;
      cycles(1);
      check("edge_tally", 32'(bus1.tally), 32'h01);
      check("edge_an_hold", 32'(bus1.an), 32'(4'b1101));
      cycles(1);
      check_disp("off_blank", 4'hF, 8'hFF);

      // Flash sequence: off, on, off, on, then idle
      cycles(8);
      check_disp("off1_end", 4'hF, 8'hFF);
      cycles(1);
      check_disp("on1_a", 4'b1110, 8'h99);
      cycles(4);
      check_disp("on1_b", 4'b1101, 8'hA4);
      cycles(1);
      check_disp("off2", 4'hF, 8'hFF);
      cycles(10);
      check_disp("off2_end", 4'hF, 8'hFF);
      cycles(1);
      check_disp("on2_a", 4'b1110, 8'h99);
      cycles(4);
      check_disp("on2_b", 4'b1101, 8'hA4);
      cycles(4);
      check_disp("idle_a", 4'b1011, 8'h79);
      cycles(4);
      check_disp("idle_b", 4'b0111, 8'hC0);

      // Second edge during ON restarts the flash from OFF
      bus1.carry_in = 1'b0;
      cycles(1);
      bus1.carry_in = 1'b1;
      cycles(1);
      check("edge2_tally", 32'(bus1.tally), 32'h02);
      cycles(10);
      check_disp("on3", 4'b1011, 8'h24);
      bus1.carry_in = 1'b0;
      cycles(1);
      bus1.carry_in = 1'b1;
      cycles(1);
      check("edge3_tally", 32'(bus1.tally), 32'h03);
      cycles(1);
      check_disp("restart_off", 4'hF, 8'hFF);
      cycles(8);
      check_disp("restart_off_end", 4'hF, 8'hFF);
      cycles(1);
      check_disp("restart_on", 4'b1101, 8'hA4);

      // Reset mid-flash returns everything to reset values immediately
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus1.carry_in = 1'b0;
      #1;
      check_disp("midrst", 4'hF, 8'hFF);
      check("midrst_tally", 32'(bus1.tally), 32'h00);
      cycles(2);
      reset = 1'b1;

      // enable=0 blanks next clock; idx keeps advancing while blanked
      cycles(4);
      check_disp("en0", 4'b1110, 8'h99);
      cycles(4);
      check_disp("en1", 4'b1101, 8'hA4);
      bus1.enable = 1'b0;
      cycles(1);
      check_disp("dis", 4'hF, 8'hFF);
      cycles(10);
      check_disp("dis_end", 4'hF, 8'hFF);
      bus1.enable = 1'b1;
      cycles(1);
      check_disp("reen", 4'b1110, 8'h99);

      // 100 pulses: tally counts through 99 and wraps to 00
      for (int i = 1; i <= 100; i++) begin
         exp_tally = 8'(((i % 100) / 10) * 16 + (i % 10));
         bus1.carry_in = 1'b1;
         cycles(1);
         check("pulse_tally", 32'(bus1.tally), 32'(exp_tally));
         bus1.carry_in = 1'b0;
         cycles(1);
      end
      check("wrap_tally", 32'(bus1.tally), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
